router_pkt_fifo: RTL and testbench
==================================

Name: router_pkt_fifo

Overview:
Parametrised, packet-aware synchronous FIFO for the 1x3 router output channels. It is the next-generation replacement for the fixed 8x16 channel FIFO. It stores a header-marker bit alongside each data word and tracks the packet currently being read out. It adds registered valid, start-of-packet and end-of-packet strobes, an occupancy count, almost-full, and sticky overflow/underflow flags, with no tri-stated outputs.

Parameters:
DATA_W, 8, data word width in bits (>= 8)
DEPTH, 16, number of entries; power of two, >= 4
LEN_MSB, 7, MSB of payload-length field inside a header word
LEN_LSB, 2, LSB of payload-length field inside a header word
AFULL_LVL, 14, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  single clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
soft_rst  in  1  synchronous flush (active-high), e.g. on channel timeout
write_enb  in  1  write request
din  in  DATA_W  write data
lfd_state  in  1  high in the same cycle as write_enb when din is a packet header
read_enb  in  1  read request
dout  out  DATA_W  registered read data
dout_valid  out  1  dout updated this cycle by an accepted read
sop_out  out  1  qualifies dout_valid: word is a header
eop_out  out  1  qualifies dout_valid: word is last of packet (parity byte)
empty  out  1  no stored words
full  out  1  DEPTH words stored
almost_full  out  1  count >= AFULL_LVL
count  out  $clog2(DEPTH)+1  current occupancy
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: read attempted while empty

Behaviour:
- Storage: DEPTH x (DATA_W+1) entries; the extra bit holds lfd_state captured with the same-cycle din. No internal delay is applied to lfd_state.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low bits are equal.
  - count = wr_ptr - rd_ptr (modulo).
  - empty, full, almost_full and count are combinational from registered pointers.
- Write accepted = write_enb & ~full. Read accepted = read_enb & ~empty.
  - Both are evaluated on pre-edge flags.
  - Simultaneous accepted read and write leaves count unchanged.
  - A write while full is dropped, and memory and pointers are unchanged. Likewise, a read while empty is dropped, with pointers unchanged.
  - Write and read while full: only the read is accepted.
  - Write and read while empty: only the write is accepted; no same-cycle bypass.
- Read latency: 1 cycle.
  - On an accepted read, dout <= mem[rd] data, and dout_valid is high the next cycle for exactly one cycle.
  - dout holds its last value otherwise; it is never driven to Z.
- Packet tracking: a remaining-word counter rem, 7 bits wide (or wider if the length field needs it).
  - On an accepted read of a header word: sop_out=1 and rem <= len+1, where len = data[LEN_MSB:LEN_LSB]. This covers the payload words plus the parity byte.
  - On an accepted read of a non-header word with rem != 0: rem <= rem-1. eop_out=1 when rem==1 before decrement.
  - A header read when len==0 and the parity byte is next sets rem=1.
  - A header read while rem != 0 (truncated packet) restarts tracking from the new header. No error flag is raised.
  - A non-header read with rem==0 is orphan data: dout_valid=1, sop_out=0, eop_out=0.
- sop_out and eop_out are registered alongside dout and are low whenever dout_valid is low.
- ovf_err / udf_err set on the first rejected write/read and hold until resetn or soft_rst.
- resetn low (synchronous), and also soft_rst high (when resetn is high) — same effect:
  - Pointers, rem, dout, dout_valid, sop_out, eop_out, ovf_err and udf_err cleared to 0.
  - Resulting flags: empty=1, full=0, almost_full=0, count=0.
  - Memory contents need not be cleared.
  - Any write or read in that cycle is ignored.
- Asserting reset or soft_rst mid-packet discards the packet. There is no further eop_out for it.

Test Plan:
1. Reset then idle, DATA_W=8, DEPTH=16 -> empty=1, full=0, count=0, dout=0, dout_valid=0. Single read with nothing stored -> udf_err=1, pointers unchanged.
2. Write header 0x0C (len=3), payload 0xA1 0xA2 0xA3, parity 0x5E; then read 5 words back-to-back -> dout sequence 0x0C,0xA1,0xA2,0xA3,0x5E each one cycle after read_enb. sop_out on first word only, eop_out on 0x5E only, count 5->0.
3. Write 16 words -> full=1, almost_full from 14th write (count=14). 17th write -> dropped, ovf_err=1. Then read all 16 -> order preserved across pointer wrap.
4. Count=8, simultaneous read and write for 20 cycles -> count stays 8, data order preserved, no error flags.
5. Mid-packet (2 of 5 words read), assert soft_rst one cycle -> next cycle empty=1, count=0, errors cleared, dout_valid=0. A new packet with header 0x04 (len=1) then reads with eop_out on its 3rd word.
6. Instantiate DATA_W=16, DEPTH=64, AFULL_LVL=60 -> full at count=64, almost_full at 60, 16-bit data intact; count port 7 bits wide.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for a router output channel: stores a header
// marker with each word and tags read data with start/end-of-packet strobes.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_MSB   = 7,
  parameter int LEN_LSB   = 2,
  parameter int AFULL_LVL = 14
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     soft_rst,
  input  logic                     write_enb,
  input  logic [DATA_W-1:0]        din,
  input  logic                     lfd_state,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     sop_out,
  output logic                     eop_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     udf_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
  localparam int REM_W = (LEN_W + 1 > 7) ? LEN_W + 1 : 7;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_LVL);

  logic [DATA_W:0]    mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [REM_W-1:0]   rem;
  logic [DATA_W:0]    rd_word;
  logic [LEN_W-1:0]   rd_len;
  logic               flush, wr_acc, rd_acc;

  assign flush       = ~resetn | soft_rst;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AFULL_C);
  assign wr_acc      = ~flush & write_enb & ~full;
  assign rd_acc      = ~flush & read_enb & ~empty;
  assign rd_word     = mem[rd_ptr[AW-1:0]];
  assign rd_len      = rd_word[LEN_MSB:LEN_LSB];

  // Storage is not cleared by reset; the header marker rides in the top bit.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= {lfd_state, din};
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rem        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sop_out    <= 1'b0;
      eop_out    <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (write_enb && full) ovf_err <= 1'b1;
      if (read_enb && empty) udf_err <= 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + PW'(1);
        dout       <= rd_word[DATA_W-1:0];
        dout_valid <= 1'b1;
        if (rd_word[DATA_W]) begin
          // A header always restarts tracking, even over a truncated packet.
          rem     <= REM_W'(rd_len) + REM_W'(1);
          sop_out <= 1'b1;
          eop_out <= 1'b0;
        end else if (rem != '0) begin
          rem     <= rem - REM_W'(1);
          sop_out <= 1'b0;
          eop_out <= (rem == REM_W'(1));
        end else begin
          sop_out <= 1'b0;
          eop_out <= 1'b0;
        end
      end else begin
        dout_valid <= 1'b0;
        sop_out    <= 1'b0;
        eop_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: default 8x16 instance plus a 16x64 instance.
module tb_router_pkt_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        soft_rst = 1'b0, write_enb = 1'b0, lfd_state = 1'b0, read_enb = 1'b0;
  logic [7:0]  din = '0, dout;
  logic        dout_valid, sop_out, eop_out, empty, full, almost_full, ovf_err, udf_err;
  logic [4:0]  count;

  logic        w_soft = 1'b0, w_write = 1'b0, w_lfd = 1'b0, w_read = 1'b0;
  logic [15:0] w_din = '0, w_dout;
  logic        w_valid, w_sop, w_eop, w_empty, w_full, w_afull, w_ovf, w_udf;
  logic [6:0]  w_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  router_pkt_fifo dut (
    .clk(clk), .resetn(resetn), .soft_rst(soft_rst), .write_enb(write_enb), .din(din),
    .lfd_state(lfd_state), .read_enb(read_enb), .dout(dout), .dout_valid(dout_valid),
    .sop_out(sop_out), .eop_out(eop_out), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .ovf_err(ovf_err), .udf_err(udf_err));

  router_pkt_fifo #(.DATA_W(16), .DEPTH(64), .AFULL_LVL(60)) dut_w (
    .clk(clk), .resetn(resetn), .soft_rst(w_soft), .write_enb(w_write), .din(w_din),
    .lfd_state(w_lfd), .read_enb(w_read), .dout(w_dout), .dout_valid(w_valid),
    .sop_out(w_sop), .eop_out(w_eop), .empty(w_empty), .full(w_full),
    .almost_full(w_afull), .count(w_count), .ovf_err(w_ovf), .udf_err(w_udf));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1; din = d; lfd_state = hdr;
    step();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic flush();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    step();
    vectors++; if ({empty, full, almost_full} !== 3'b100) begin miscompares++; $display("FAIL reset_flags got %b want 100", {empty, full, almost_full}); end
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout got %h/%b want 00/0", dout, dout_valid); end
    vectors++; if ({ovf_err, udf_err} !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", {ovf_err, udf_err}); end
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
    vectors++; if (udf_err !== 1'b1) begin miscompares++; $display("FAIL underflow got %b want 1", udf_err); end
    vectors++; if (empty !== 1'b1 || count !== 5'd0 || dout_valid !== 1'b0) begin miscompares++; $display("FAIL underflow_ptrs got e=%b c=%0d v=%b want 1/0/0", empty, count, dout_valid); end
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [5];
    exp_d = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
    flush();
    for (int i = 0; i < 5; i++) push(exp_d[i], i == 0);
    vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL pkt_count got %0d want 5", count); end
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (dout !== exp_d[i] || dout_valid !== 1'b1) begin miscompares++; $display("FAIL pkt_data[%0d] got %h/%b want %h/1", i, dout, dout_valid, exp_d[i]); end
      vectors++; if (sop_out !== (i == 0) || eop_out !== (i == 4)) begin miscompares++; $display("FAIL pkt_strobe[%0d] got sop=%b eop=%b", i, sop_out, eop_out); end
      vectors++; if (count !== 5'(4 - i)) begin miscompares++; $display("FAIL pkt_cnt[%0d] got %0d want %0d", i, count, 4 - i); end
    end
    read_enb = 1'b0;
    step();
    vectors++; if (dout_valid !== 1'b0 || sop_out !== 1'b0 || eop_out !== 1'b0 || dout !== 8'h5E) begin miscompares++; $display("FAIL pkt_idle got v=%b s=%b e=%b d=%h want 0/0/0/5e", dout_valid, sop_out, eop_out, dout); end
  endtask

  // Pointers sit at 5 from the previous test, so 16 writes cross the wrap.
  task automatic test_full();
    for (int n = 1; n <= 16; n++) begin
      push(8'(8'h10 + n - 1), 1'b0);
      vectors++; if (count !== 5'(n)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", n, count, n); end
      vectors++; if (almost_full !== (n >= 14)) begin miscompares++; $display("FAIL fill_afull[%0d] got %b want %b", n, almost_full, n >= 14); end
      vectors++; if (full !== (n == 16)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", n, full, n == 16); end
    end
    push(8'hEE, 1'b0);
    vectors++; if (ovf_err !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin miscompares++; $display("FAIL overflow got ovf=%b c=%0d f=%b want 1/16/1", ovf_err, count, full); end
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++; if (dout !== 8'(8'h10 + i) || dout_valid !== 1'b1 || sop_out !== 1'b0 || eop_out !== 1'b0) begin miscompares++; $display("FAIL drain[%0d] got %h v=%b s=%b e=%b want %h/1/0/0", i, dout, dout_valid, sop_out, eop_out, 8'(8'h10 + i)); end
    end
    read_enb = 1'b0;
    step();
    vectors++; if (empty !== 1'b1 || dout !== 8'h1F) begin miscompares++; $display("FAIL drain_end got e=%b d=%h want 1/1f", empty, dout); end
  endtask

  task automatic test_back_to_back();
    flush();
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i), 1'b0);
    write_enb = 1'b1; read_enb = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din = 8'(8'h38 + k);
      step();
      vectors++; if (dout !== 8'(8'h30 + k) || dout_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_data[%0d] got %h/%b want %h/1", k, dout, dout_valid, 8'(8'h30 + k)); end
      vectors++; if (count !== 5'd8) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d want 8", k, count); end
    end
    write_enb = 1'b0; read_enb = 1'b0;
    step();
    vectors++; if ({ovf_err, udf_err} !== 2'b00) begin miscompares++; $display("FAIL b2b_err got %b want 00", {ovf_err, udf_err}); end
  endtask

  task automatic test_soft_rst();
    flush();
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
    push(8'h0C, 1'b1); push(8'hB1, 1'b0); push(8'hB2, 1'b0); push(8'hB3, 1'b0); push(8'hB4, 1'b0);
    read_enb = 1'b1;
    step(); step();
    vectors++; if (dout !== 8'hB1 || udf_err !== 1'b1 || count !== 5'd3) begin miscompares++; $display("FAIL mid_pkt got d=%h u=%b c=%0d want b1/1/3", dout, udf_err, count); end
    // Flush with a read and write pending in the same cycle: both must be ignored.
    soft_rst = 1'b1; write_enb = 1'b1; din = 8'h77;
    step();
    soft_rst = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    vectors++; if (empty !== 1'b1 || count !== 5'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin miscompares++; $display("FAIL soft_rst got e=%b c=%0d v=%b d=%h want 1/0/0/00", empty, count, dout_valid, dout); end
    vectors++; if ({ovf_err, udf_err} !== 2'b00) begin miscompares++; $display("FAIL soft_rst_err got %b want 00", {ovf_err, udf_err}); end
    push(8'h04, 1'b1); push(8'hC1, 1'b0); push(8'hC2, 1'b0);
    read_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (sop_out !== (i == 0) || eop_out !== (i == 2) || dout_valid !== 1'b1) begin miscompares++; $display("FAIL new_pkt[%0d] got sop=%b eop=%b v=%b", i, sop_out, eop_out, dout_valid); end
    end
    read_enb = 1'b0;
    step();
    vectors++; if (dout !== 8'hC2 || empty !== 1'b1) begin miscompares++; $display("FAIL new_pkt_end got d=%h e=%b want c2/1", dout, empty); end
  endtask

  task automatic test_wide();
    w_write = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      w_din = 16'((n - 1) * 16'h0101) ^ 16'hC3A5;
      step();
      vectors++; if (w_count !== 7'(n) || w_afull !== (n >= 60) || w_full !== (n == 64)) begin miscompares++; $display("FAIL wide_fill[%0d] got c=%0d af=%b f=%b", n, w_count, w_afull, w_full); end
    end
    w_din = 16'hFFFF;
    step();
    w_write = 1'b0;
    vectors++; if (w_ovf !== 1'b1 || w_count !== 7'd64) begin miscompares++; $display("FAIL wide_ovf got o=%b c=%0d want 1/64", w_ovf, w_count); end
    w_read = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      vectors++; if (w_dout !== (16'(i * 16'h0101) ^ 16'hC3A5) || w_valid !== 1'b1) begin miscompares++; $display("FAIL wide_data[%0d] got %h/%b want %h/1", i, w_dout, w_valid, 16'(i * 16'h0101) ^ 16'hC3A5); end
    end
    w_read = 1'b0;
    step();
    vectors++; if (w_empty !== 1'b1 || w_udf !== 1'b0 || w_valid !== 1'b0) begin miscompares++; $display("FAIL wide_end got e=%b u=%b v=%b want 1/0/0", w_empty, w_udf, w_valid); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_soft_rst();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
